// File: rtl/boot_loader.sv
// boot_loader: receives a boot image over a valid/ready byte stream and writes
// it into memory while holding the CPU in reset, then releases the CPU.
//
// Stream format: addr lo, addr hi, len lo, len hi, then len payload bytes.
// After the final memory write, CPU_R stays high for HOLD_CYCLES more cycles,
// then the loader parks in ST_DONE (CPU_R=0, DONE=1) until R.
//
// Ports:
//   CLK       in   1  clock, all state changes on the rising edge
//   R         in   1  synchronous active-high reset
//   IN_VALID  in   1  upstream byte valid
//   IN_DATA   in   8  upstream byte
//   IN_READY  out  1  loader accepts a byte this cycle
//   ADDR      out 16  memory write address
//   DATA      out  8  memory write data
//   WE        out  1  memory write enable, one cycle per payload byte
//   CPU_R     out  1  CPU reset; high while the loader owns memory
//   DONE      out  1  load complete and CPU released
module boot_loader #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        R,
    input  logic        IN_VALID,
    input  logic [7:0]  IN_DATA,
    output logic        IN_READY,
    output logic [15:0] ADDR,
    output logic [7:0]  DATA,
    output logic        WE,
    output logic        CPU_R,
    output logic        DONE
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   r_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_in_ready;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic            r_we;
    logic            r_cpu_r;
    logic            r_done;

    logic            w_hs;
    logic [AW-1:0]   w_len;

    // r_in_ready is only high in the parsing states, so it also gates HOLD/DONE
    assign w_hs  = IN_VALID && r_in_ready;
    assign w_len = {IN_DATA, r_cnt[7:0]};

    // Parser / writer FSM. IN_READY is registered from the next state, so it
    // drops in the same cycle the final byte's write is presented.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_state    <= ST_ADDR_LO;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_hold_cnt <= '0;
            r_in_ready <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_cpu_r    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_ADDR_LO: begin
                    r_in_ready <= 1'b1;
                    if (w_hs) begin
                        r_ptr[7:0] <= IN_DATA;
                        r_state    <= ST_ADDR_HI;
                    end
                end
                ST_ADDR_HI: begin
                    r_in_ready <= 1'b1;
                    if (w_hs) begin
                        r_ptr[15:8] <= IN_DATA;
                        r_state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    r_in_ready <= 1'b1;
                    if (w_hs) begin
                        r_cnt[7:0] <= IN_DATA;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    r_in_ready <= 1'b1;
                    if (w_hs) begin
                        r_cnt <= w_len;
                        // Empty image: skip straight to the hold phase
                        if (w_len == '0) begin
                            r_state    <= ST_HOLD;
                            r_in_ready <= 1'b0;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    r_in_ready <= 1'b1;
                    if (w_hs) begin
                        r_addr <= r_ptr;
                        r_data <= IN_DATA;
                        r_we   <= 1'b1;
                        r_ptr  <= r_ptr + AW'(1);
                        r_cnt  <= r_cnt - AW'(1);
                        if (r_cnt == AW'(1)) begin
                            r_state    <= ST_HOLD;
                            r_in_ready <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    // The cycle carrying the last WE is not a hold cycle; the
                    // HOLD_CYCLES cycles after it are, then CPU_R drops.
                    r_in_ready <= 1'b0;
                    if (r_hold_cnt == HW'(HOLD_CYCLES)) begin
                        r_state <= ST_DONE;
                        r_cpu_r <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                ST_DONE: begin
                    r_in_ready <= 1'b0;
                    r_cpu_r    <= 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                    r_state    <= ST_ADDR_LO;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY = r_in_ready;
    assign ADDR     = r_addr;
    assign DATA     = r_data;
    assign WE       = r_we;
    assign CPU_R    = r_cpu_r;
    assign DONE     = r_done;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized scoreboard bench for boot_loader.
// The driver pushes each expected memory write (address, data, cycle) as the
// payload byte is handed over; a monitor sampling 2 time units after each
// rising edge pops and compares, and checks DONE/CPU_R and ADDR/DATA hold.
module tb_boot_loader;

    localparam int unsigned HOLD = 2;
    localparam int          BIG  = 32'h7fff_ffff;

    logic        CLK = 1'b0;
    logic        R = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_READY;
    logic [15:0] ADDR;
    logic [7:0]  DATA;
    logic        WE;
    logic        CPU_R;
    logic        DONE;

    boot_loader #(.HOLD_CYCLES(HOLD)) dut (
        .CLK      (CLK),
        .R        (R),
        .IN_VALID (IN_VALID),
        .IN_DATA  (IN_DATA),
        .IN_READY (IN_READY),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .WE       (WE),
        .CPU_R    (CPU_R),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_w;
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cycle = BIG;
    int          last_hs = 0;
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: memory writes, output hold while idle, CPU release timing
    always @(posedge CLK) begin
        #2;
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            mon_w = exp_q.pop_front();
            chk("we_pulse", 32'(WE), 32'(1));
            chk("we_addr", 32'(ADDR), 32'(mon_w.a));
            chk("we_data", 32'(DATA), 32'(mon_w.d));
            m_addr = mon_w.a;
            m_data = mon_w.d;
        end else begin
            chk("we_idle", 32'(WE), 32'(0));
            chk("addr_hold", 32'(ADDR), 32'(m_addr));
            chk("data_hold", 32'(DATA), 32'(m_data));
        end
        chk("done", 32'(DONE), 32'(cyc >= done_cycle));
        chk("cpu_r", 32'(CPU_R), 32'(cyc < done_cycle));
    end

    // Hand over one byte, optionally after random idle cycles; called at a negedge
    task automatic drv_byte(input logic [7:0] b, input int gap_pct, input bit is_pay,
                            input logic [15:0] a);
        for (int g = 0; g < 4; g++) begin
            if (int'($urandom_range(99, 0)) >= gap_pct) break;
            IN_VALID = 1'b0;
            IN_DATA  = 8'($urandom);
            @(negedge CLK);
        end
        IN_VALID = 1'b1;
        IN_DATA  = b;
        chk("in_ready_hi", 32'(IN_READY), 32'(1));
        last_hs = cyc + 1;
        if (is_pay) exp_q.push_back('{a, b, last_hs});
        @(negedge CLK);
    endtask

    // Send the first nb bytes of stream s; a complete stream arms the DONE model
    task automatic send_stream(input logic [7:0] s[$], input int gap_pct, input int nb);
        logic [15:0] start;
        logic [15:0] len;
        start = {s[1], s[0]};
        len   = {s[3], s[2]};
        for (int k = 0; k < nb; k++) begin
            drv_byte(s[k], gap_pct, k >= 4, 16'(int'(start) + k - 4));
        end
        IN_VALID = 1'b0;
        if (nb == 4 + int'(len)) done_cycle = last_hs + int'(HOLD) + 1;
    endtask

    // Wait out the hold phase; with extra set, keep offering bytes the loader must ignore
    task automatic wait_tail(input bit extra);
        int n;
        n = done_cycle - cyc + 3;
        for (int i = 0; i < n; i++) begin
            IN_VALID = extra;
            IN_DATA  = 8'($urandom);
            chk("in_ready_lo", 32'(IN_READY), 32'(0));
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
    endtask

    // Reset for n edges; vld keeps a byte on offer during reset (abort case)
    task automatic do_reset(input int n, input bit vld);
        chk("q_empty", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        R          = 1'b1;
        IN_VALID   = vld;
        IN_DATA    = 8'h77;
        done_cycle = BIG;
        m_addr     = 16'h0000;
        m_data     = 8'h00;
        repeat (n) @(negedge CLK);
        chk("rst_in_ready", 32'(IN_READY), 32'(0));
        chk("rst_we", 32'(WE), 32'(0));
        chk("rst_addr", 32'(ADDR), 32'(0));
        chk("rst_data", 32'(DATA), 32'(0));
        chk("rst_cpu_r", 32'(CPU_R), 32'(1));
        chk("rst_done", 32'(DONE), 32'(0));
        R        = 1'b0;
        IN_VALID = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s[$];
        logic [15:0] st;
        int          len;

        @(negedge CLK);
        do_reset(3, 1'b0);

        // Basic load with IN_VALID held high, then extra bytes during hold/done
        s = '{8'h00, 8'h02, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_stream(s, 0, s.size());
        wait_tail(1'b1);

        // Zero-length image
        do_reset(1, 1'b0);
        s = '{8'h34, 8'h12, 8'h00, 8'h00};
        send_stream(s, 0, s.size());
        wait_tail(1'b1);

        // Address wrap-around
        do_reset(2, 1'b0);
        s = '{8'hFE, 8'hFF, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(s, 0, s.size());
        wait_tail(1'b0);

        // Gapped payload of length 5
        do_reset(1, 1'b0);
        s = '{8'h00, 8'h10, 8'h05, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_stream(s, 50, s.size());
        wait_tail(1'b0);

        // Mid-load reset after 2 of 4 payload bytes, a byte offered during reset
        do_reset(1, 1'b0);
        s = '{8'h00, 8'h30, 8'h04, 8'h00, 8'h51, 8'h52, 8'h53, 8'h54};
        send_stream(s, 0, 6);
        do_reset(1, 1'b1);
        s = '{8'h80, 8'h40, 8'h03, 8'h00, 8'hC1, 8'hC2, 8'hC3};
        send_stream(s, 0, s.size());
        wait_tail(1'b1);

        // Randomized images, some straddling the top of the address space
        for (int t = 0; t < 8; t++) begin
            do_reset(1, 1'b0);
            st  = ($urandom_range(1, 0) == 1) ? 16'(16'hFFF8 + $urandom_range(7, 0))
                                              : 16'($urandom);
            len = int'($urandom_range(9, 0));
            s.delete();
            s.push_back(st[7:0]);
            s.push_back(st[15:8]);
            s.push_back(8'(len));
            s.push_back(8'h00);
            for (int k = 0; k < len; k++) s.push_back(8'($urandom));
            send_stream(s, 30, s.size());
            wait_tail(t[0]);
        end

        chk("q_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
